// File: rtl/spi_arb_pkg.sv
// Shared constants for the SPI master arbiter: default parameters and FSM encoding.
// States stay plain 2-bit constants so legacy netlists and probes keep their values.
package spi_arb_pkg;

    localparam int unsigned DEF_N              = 16;
    localparam int unsigned DEF_NUM_REQ        = 4;
    localparam int unsigned DEF_GAP_CYCLES     = 2;
    localparam int unsigned DEF_LAUNCH_TIMEOUT = 8;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t ST_IDLE    = 2'd0;
    localparam arb_state_t ST_WAIT_CS = 2'd1;
    localparam arb_state_t ST_BUSY    = 2'd2;
    localparam arb_state_t ST_GAP     = 2'd3;

    // Index width for a pool of n requesters; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit at or above ptr, wrapping.
module rr_pick
    import spi_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ,
    parameter int unsigned PTR_W   = idx_width(DEF_NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   rr_ptr,
    output logic               valid,
    output logic [PTR_W-1:0]   index
);

    always_comb begin
        int unsigned cand;
        valid = 1'b0;
        index = '0;
        cand  = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = int'(rr_ptr) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!valid && req[cand]) begin
                valid = 1'b1;
                index = cand[PTR_W-1:0];
            end
        end
    end

endmodule

// File: rtl/spi_arbiter.sv
// Round-robin arbiter sharing one SPI master among NUM_REQ requesters.
// Every output is a register; the master's cs line paces the WAIT_CS/BUSY states.
module spi_arbiter
    import spi_arb_pkg::*;
#(
    parameter int unsigned N              = DEF_N,
    parameter int unsigned NUM_REQ        = DEF_NUM_REQ,
    parameter int unsigned GAP_CYCLES     = DEF_GAP_CYCLES,
    parameter int unsigned LAUNCH_TIMEOUT = DEF_LAUNCH_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ*N-1:0] req_data,
    output logic [NUM_REQ-1:0]   gnt,
    output logic [NUM_REQ-1:0]   done,
    output logic                 err,
    output logic                 busy,
    output logic                 spi_enable,
    output logic [N-1:0]         spi_data,
    input  logic                 spi_cs
);

    localparam int unsigned PTR_W = idx_width(NUM_REQ);
    localparam int unsigned TMO_W = idx_width(LAUNCH_TIMEOUT + 1);
    localparam int unsigned GAP_W = idx_width(GAP_CYCLES + 1);

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(LAUNCH_TIMEOUT - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [PTR_W-1:0] PTR_TOP  = PTR_W'(NUM_REQ - 1);

    arb_state_t       state;
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] owner;
    logic [TMO_W-1:0] tmo_cnt;
    logic [GAP_W-1:0] gap_cnt;

    logic             pick_valid;
    logic [PTR_W-1:0] pick_idx;
    logic [N-1:0]     win_data;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .req    (req),
        .rr_ptr (rr_ptr),
        .valid  (pick_valid),
        .index  (pick_idx)
    );

    always_comb begin
        win_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (pick_idx == i[PTR_W-1:0]) begin
                win_data = req_data[i*N +: N];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            rr_ptr     <= '0;
            owner      <= '0;
            tmo_cnt    <= '0;
            gap_cnt    <= '0;
            gnt        <= '0;
            done       <= '0;
            err        <= 1'b0;
            busy       <= 1'b0;
            spi_enable <= 1'b0;
            spi_data   <= '0;
        end else begin
            gnt  <= '0;
            done <= '0;
            err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        spi_data      <= win_data;
                        gnt[pick_idx] <= 1'b1;
                        owner         <= pick_idx;
                        rr_ptr        <= (pick_idx == PTR_TOP) ? '0 : pick_idx + PTR_W'(1);
                        spi_enable    <= 1'b1;
                        tmo_cnt       <= '0;
                        busy          <= 1'b1;
                        state         <= ST_WAIT_CS;
                    end
                end
                ST_WAIT_CS: begin
                    if (!spi_cs) begin
                        spi_enable <= 1'b0;
                        state      <= ST_BUSY;
                    end else if (tmo_cnt == TMO_LAST) begin
                        // Master never launched: report and back off without a done.
                        err        <= 1'b1;
                        spi_enable <= 1'b0;
                        gap_cnt    <= '0;
                        state      <= ST_GAP;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                ST_BUSY: begin
                    if (spi_cs) begin
                        done[owner] <= 1'b1;
                        gap_cnt     <= '0;
                        state       <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                default: begin
                    busy       <= 1'b0;
                    spi_enable <= 1'b0;
                    state      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_arbiter.sv
// Directed bench for spi_arbiter with a small registered SPI master model (32-cycle cs-low frame).
module tb_spi_arbiter;

    localparam int N       = 16;
    localparam int NUM_REQ = 4;
    localparam int GAP     = 2;
    // Launch edge, master registering enable, 2N cs-low cycles, done edge, GAP, one IDLE arbitration cycle.
    localparam int SPACING = 3 + 2*N + GAP;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NUM_REQ-1:0]   req;
    logic [NUM_REQ*N-1:0] req_data;
    logic [NUM_REQ-1:0]   gnt;
    logic [NUM_REQ-1:0]   done;
    logic                 err;
    logic                 busy;
    logic                 spi_enable;
    logic [N-1:0]         spi_data;
    logic                 spi_cs;

    int n_checks = 0;
    int n_err    = 0;

    spi_arbiter #(
        .N              (N),
        .NUM_REQ        (NUM_REQ),
        .GAP_CYCLES     (GAP),
        .LAUNCH_TIMEOUT (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .req_data   (req_data),
        .gnt        (gnt),
        .done       (done),
        .err        (err),
        .busy       (busy),
        .spi_enable (spi_enable),
        .spi_data   (spi_data),
        .spi_cs     (spi_cs)
    );

    always #5 clk = ~clk;

    // SPI master model: not reset by rst_n, shifts MSB-first, captures mosi mid-bit.
    logic         m_busy = 1'b0;
    logic         m_cs   = 1'b1;
    logic         cs_tie = 1'b0;
    int           m_cnt  = 0;
    logic [N-1:0] m_sh   = '0;
    logic [N-1:0] m_cap  = '0;

    assign spi_cs = cs_tie | m_cs;

    always @(posedge clk) begin
        if (!m_busy) begin
            if (spi_enable && !cs_tie) begin
                m_busy <= 1'b1;
                m_cs   <= 1'b0;
                m_cnt  <= 0;
                m_sh   <= spi_data;
            end
        end else begin
            if (m_cnt[0] == 1'b0) m_cap <= {m_cap[N-2:0], m_sh[N-1]};
            else                  m_sh  <= m_sh << 1;
            if (m_cnt == 2*N-1) begin
                m_cs   <= 1'b1;
                m_busy <= 1'b0;
            end else begin
                m_cnt <= m_cnt + 1;
            end
        end
    end

    int   cyc = 0;
    int   cs_rise_cyc = 0;
    int   done_cnt = 0;
    int   err_cnt = 0;
    int   viol = 0;
    logic cs_prev = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        cs_prev <= spi_cs;
        if (spi_cs && !cs_prev) cs_rise_cyc <= cyc;
        if (|done) done_cnt <= done_cnt + 1;
        if (err) err_cnt <= err_cnt + 1;
        if ($countones(gnt) > 1 || $countones(done) > 1 ||
            (int'(|gnt) + int'(|done) + int'(err)) > 1)
            viol <= viol + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_gnt(input string tag, output int idx, output int at);
        logic timed_out;
        idx = -1;
        at = 0;
        timed_out = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (|gnt) begin
                at = cyc;
                for (int i = 0; i < NUM_REQ; i++) if (gnt[i]) idx = i;
                timed_out = 1'b0;
                break;
            end
        end
        check({tag, "_gnt_timeout"}, timed_out, 1'b0);
    endtask

    task automatic wait_idle(input string tag);
        logic timed_out;
        timed_out = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (!busy && !m_busy) begin
                timed_out = 1'b0;
                break;
            end
        end
        check({tag, "_idle_timeout"}, timed_out, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt"}, gnt, '0);
        check({tag, "_done"}, done, '0);
        check({tag, "_err"}, err, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_enable"}, spi_enable, 1'b0);
        check({tag, "_data"}, spi_data, '0);
    endtask

    initial begin
        int idx, t, tprev, t_done, k_err, d0;
        logic found;
        int exp_c[5] = '{0, 1, 2, 3, 0};
        int exp_f[3] = '{3, 1, 3};

        rst_n    = 1'b0;
        req      = '0;
        req_data = {16'hD004, 16'hC003, 16'hB002, 16'hA5C3};
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        // Single request
        @(negedge clk);
        req = 4'b0001;
        wait_gnt("single", idx, t);
        check("single_gnt", gnt, 4'b0001);
        check("single_data", spi_data, 16'hA5C3);
        check("single_enable", spi_enable, 1'b1);
        check("single_busy", busy, 1'b1);
        req = '0;
        @(negedge clk);
        check("single_gnt_pulse", gnt, '0);
        found = 1'b0;
        t_done = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (|done) begin
                found = 1'b1;
                t_done = cyc;
                break;
            end
        end
        check("single_done_seen", found, 1'b1);
        check("single_done", done, 4'b0001);
        check("single_done_lat", t_done - cs_rise_cyc, 1);
        check("single_mosi", m_cap, 16'hA5C3);
        check("single_gap0_busy", busy, 1'b1);
        @(negedge clk);
        check("single_done_pulse", done, '0);
        check("single_gap1_busy", busy, 1'b1);
        @(negedge clk);
        check("single_idle_busy", busy, 1'b0);
        check("single_data_hold", spi_data, 16'hA5C3);

        // Contention from rr_ptr=0
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        req = 4'b1111;
        tprev = 0;
        for (int k = 0; k < 5; k++) begin
            wait_gnt("cont", idx, t);
            check($sformatf("cont_idx%0d", k), idx, exp_c[k]);
            check($sformatf("cont_data%0d", k), spi_data, req_data[exp_c[k]*N +: N]);
            if (k > 0) check($sformatf("cont_space%0d", k), t - tprev, SPACING);
            tprev = t;
        end
        req = '0;
        wait_idle("cont");

        // Fairness: move rr_ptr to 2, then 1010 held
        req = 4'b0010;
        wait_gnt("fair_pre", idx, t);
        check("fair_pre_idx", idx, 1);
        req = '0;
        wait_idle("fair_pre");
        req = 4'b1010;
        for (int k = 0; k < 3; k++) begin
            wait_gnt("fair", idx, t);
            check($sformatf("fair_idx%0d", k), idx, exp_f[k]);
        end
        req = '0;
        wait_idle("fair");

        // Launch timeout with cs tied high
        cs_tie = 1'b1;
        d0 = done_cnt;
        req = 4'b0100;
        wait_gnt("tmo", idx, t);
        check("tmo_idx", idx, 2);
        req = '0;
        k_err = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 7) check("tmo_enable_held", spi_enable, 1'b1);
            if (err) begin
                k_err = k;
                break;
            end
        end
        check("tmo_latency", k_err, 8);
        check("tmo_enable_drop", spi_enable, 1'b0);
        check("tmo_busy_gap", busy, 1'b1);
        @(negedge clk);
        check("tmo_err_pulse", err, 1'b0);
        @(negedge clk);
        check("tmo_idle", busy, 1'b0);
        check("tmo_no_done", done_cnt - d0, 0);
        cs_tie = 1'b0;

        // Reset in the middle of a frame
        req = 4'b0001;
        wait_gnt("rst", idx, t);
        check("rst_idx", idx, 0);
        req = '0;
        repeat (11) @(negedge clk);
        check("rst_mid_busy", busy, 1'b1);
        check("rst_mid_cs", spi_cs, 1'b0);
        d0 = done_cnt;
        rst_n = 1'b0;
        @(negedge clk);
        check_all_zero("rst_mid");
        rst_n = 1'b1;
        wait_idle("rst");
        repeat (4) @(negedge clk);
        check("rst_no_done", done_cnt - d0, 0);
        req = 4'b0001;
        wait_gnt("rst_after", idx, t);
        check("rst_after_idx", idx, 0);
        check("rst_after_data", spi_data, 16'hA5C3);
        req = '0;
        wait_idle("rst_after");

        check("exclusive_pulses", viol, 0);
        check("total_done", done_cnt, 11);
        check("total_err", err_cnt, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
